ysyx_22040750_lsu_stage: RTL and testbench

- MEM-stage producer feeding the MEM/WB pipeline register.
- Accepts one instruction from EX/MEM via valid/allowin and, for loads/stores, runs a request/response transaction on the data-memory bus.
- Presents the result to MEM/WB via O_MEM_WB_valid / I_MEM_WB_allowin.
- Non-memory instructions pass through with one register stage.

---
 rtl/ysyx_22040750_lsu_pkg.sv | 15 +
 rtl/ysyx_22040750_lsu_timeout_cnt.sv | 27 ++
 rtl/ysyx_22040750_lsu_stage.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22040750_lsu_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_lsu_pkg.sv
// Shared definitions for the LSU (MEM) stage: FSM encoding and parameter defaults.
package ysyx_22040750_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } lsu_state_e;

    localparam int unsigned LSU_ADDR_W         = 32;
    localparam int unsigned LSU_DATA_W         = 64;
    localparam int unsigned LSU_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/ysyx_22040750_lsu_timeout_cnt.sv
// 8-bit response-wait counter; flags expiry on the LIMIT-th enabled cycle after a clear.
module ysyx_22040750_lsu_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic I_sys_clk,
    input  logic I_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Count value k is visible during the (k+1)-th cycle, so LIMIT-1 marks the last one.
    assign expired = en && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/ysyx_22040750_lsu_stage.sv
// MEM stage: captures one EX/MEM instruction, runs a dmem req/resp for loads/stores, holds result for MEM/WB.
// Optional response timeout with sticky O_dmem_err: define YSYX_22040750_LSU_TIMEOUT_EN.
module ysyx_22040750_lsu_stage
    import ysyx_22040750_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = LSU_ADDR_W,
    parameter int unsigned DATA_W         = LSU_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
    input  logic                I_sys_clk,
    input  logic                I_rst,
    input  logic                I_EX_MEM_valid,
    output logic                O_EX_MEM_allowin,
    input  logic                I_mem_ren,
    input  logic                I_mem_wen,
    input  logic [ADDR_W-1:0]   I_addr,
    input  logic [DATA_W-1:0]   I_wdata,
    input  logic [DATA_W/8-1:0] I_wstrb,
    input  logic                I_reg_wen,
    input  logic [4:0]          I_rd_addr,
    output logic                O_dmem_req,
    output logic                O_dmem_we,
    output logic [ADDR_W-1:0]   O_dmem_addr,
    output logic [DATA_W-1:0]   O_dmem_wdata,
    output logic [DATA_W/8-1:0] O_dmem_wstrb,
    input  logic                I_dmem_gnt,
    input  logic                I_dmem_rvalid,
    input  logic [DATA_W-1:0]   I_dmem_rdata,
    output logic                O_MEM_WB_valid,
    input  logic                I_MEM_WB_allowin,
    output logic [DATA_W-1:0]   O_mem_data,
    output logic [2:0]          O_mem_shamt,
    output logic [ADDR_W-1:0]   O_alu_out,
    output logic                O_reg_wen,
    output logic [4:0]          O_rd_addr
`ifdef YSYX_22040750_LSU_TIMEOUT_EN
    ,
    output logic                O_dmem_err
`endif
);

    lsu_state_e state, state_nx;

    logic                accept;
    logic                is_mem_in;
    logic                resp_timeout;
    logic                ren_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                reg_wen_q;
    logic [4:0]          rd_q;
    logic [DATA_W-1:0]   mem_data_q;

    assign O_EX_MEM_allowin = (state == IDLE) || ((state == HOLD) && I_MEM_WB_allowin);
    assign accept           = O_EX_MEM_allowin && I_EX_MEM_valid;
    assign is_mem_in        = I_mem_ren || I_mem_wen;

`ifdef YSYX_22040750_LSU_TIMEOUT_EN
    logic cnt_expired;
    logic err_q;

    ysyx_22040750_lsu_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .I_sys_clk (I_sys_clk),
        .I_rst     (I_rst),
        .clr       ((state == REQ) && I_dmem_gnt),
        .en        (state == RESP),
        .expired   (cnt_expired)
    );

    assign resp_timeout = cnt_expired && !I_dmem_rvalid;

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            err_q <= 1'b0;
        end else if ((state == RESP) && resp_timeout) begin
            err_q <= 1'b1;
        end
    end

    assign O_dmem_err = err_q;
`else
    logic unused_timeout_cfg;

    assign resp_timeout       = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // rvalid only matters in RESP; a grant cycle with rvalid counts as grant alone.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    state_nx = is_mem_in ? REQ : HOLD;
                end else if ((state == HOLD) && I_MEM_WB_allowin) begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                if (I_dmem_gnt) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (I_dmem_rvalid || resp_timeout) begin
                    state_nx = HOLD;
                end
            end
        endcase
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            ren_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            reg_wen_q  <= 1'b0;
            rd_q       <= '0;
            mem_data_q <= '0;
        end else if (accept) begin
            ren_q      <= I_mem_ren;
            we_q       <= I_mem_wen;
            addr_q     <= I_addr;
            wdata_q    <= I_wdata;
            wstrb_q    <= I_wstrb;
            reg_wen_q  <= I_reg_wen;
            rd_q       <= I_rd_addr;
            mem_data_q <= '0;
        end else if ((state == RESP) && I_dmem_rvalid && ren_q) begin
            mem_data_q <= I_dmem_rdata;
        end
    end

    // Request is decoded from state so an asynchronous reset drops it at once.
    assign O_dmem_req     = (state == REQ);
    assign O_dmem_we      = we_q;
    assign O_dmem_addr    = {addr_q[ADDR_W-1:3], 3'b000};
    assign O_dmem_wdata   = wdata_q;
    assign O_dmem_wstrb   = wstrb_q;

    assign O_MEM_WB_valid = (state == HOLD);
    assign O_mem_data     = mem_data_q;
    assign O_mem_shamt    = addr_q[2:0];
    assign O_alu_out      = addr_q;
    assign O_reg_wen      = reg_wen_q;
    assign O_rd_addr      = rd_q;

endmodule

// File: tb/tb_ysyx_22040750_lsu_stage.sv
// Scoreboard bench for the LSU stage: directed vectors push expected results, a monitor checks MEM/WB handshakes.
`timescale 1ns/1ps
module tb_ysyx_22040750_lsu_stage;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;

    typedef struct {
        logic [AW-1:0] alu;
        logic [DW-1:0] data;
        logic          reg_wen;
        logic [4:0]    rd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ex_valid = 1'b0;
    logic            ex_allowin;
    logic            ren = 1'b0;
    logic            wen = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            reg_wen = 1'b0;
    logic [4:0]      rd = '0;
    logic            dmem_req;
    logic            dmem_we;
    logic [AW-1:0]   dmem_addr;
    logic [DW-1:0]   dmem_wdata;
    logic [DW/8-1:0] dmem_wstrb;
    logic            gnt = 1'b0;
    logic            rvalid = 1'b0;
    logic [DW-1:0]   rdata = '0;
    logic            mwb_valid;
    logic            mwb_allowin = 1'b1;
    logic [DW-1:0]   mem_data;
    logic [2:0]      mem_shamt;
    logic [AW-1:0]   alu_out;
    logic            o_reg_wen;
    logic [4:0]      o_rd;
`ifdef YSYX_22040750_LSU_TIMEOUT_EN
    logic            dmem_err;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ysyx_22040750_lsu_stage #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .I_sys_clk        (clk),
        .I_rst            (rst),
        .I_EX_MEM_valid   (ex_valid),
        .O_EX_MEM_allowin (ex_allowin),
        .I_mem_ren        (ren),
        .I_mem_wen        (wen),
        .I_addr           (addr),
        .I_wdata          (wdata),
        .I_wstrb          (wstrb),
        .I_reg_wen        (reg_wen),
        .I_rd_addr        (rd),
        .O_dmem_req       (dmem_req),
        .O_dmem_we        (dmem_we),
        .O_dmem_addr      (dmem_addr),
        .O_dmem_wdata     (dmem_wdata),
        .O_dmem_wstrb     (dmem_wstrb),
        .I_dmem_gnt       (gnt),
        .I_dmem_rvalid    (rvalid),
        .I_dmem_rdata     (rdata),
        .O_MEM_WB_valid   (mwb_valid),
        .I_MEM_WB_allowin (mwb_allowin),
        .O_mem_data       (mem_data),
        .O_mem_shamt      (mem_shamt),
        .O_alu_out        (alu_out),
        .O_reg_wen        (o_reg_wen),
        .O_rd_addr        (o_rd)
`ifdef YSYX_22040750_LSU_TIMEOUT_EN
        ,
        .O_dmem_err       (dmem_err)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        ex_valid = 1'b0;
        ren      = 1'b0;
        wen      = 1'b0;
        addr     = '0;
        wdata    = '0;
        wstrb    = '0;
        reg_wen  = 1'b0;
        rd       = '0;
    endtask

    task automatic issue(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW/8-1:0] ws,
                         input logic rw, input logic [4:0] d);
        ex_valid = 1'b1;
        ren      = r;
        wen      = w;
        addr     = a;
        wdata    = wd;
        wstrb    = ws;
        reg_wen  = rw;
        rd       = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rw, input logic [4:0] r);
        exp_t e;
        e.alu     = a;
        e.data    = d;
        e.reg_wen = rw;
        e.rd      = r;
        exp_q.push_back(e);
    endtask

    // Monitor: every MEM/WB handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && mwb_valid && mwb_allowin) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {32'd0, alu_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_alu_out", {32'd0, alu_out}, {32'd0, e.alu});
                chk("sb_mem_shamt", {61'd0, mem_shamt}, {61'd0, e.alu[2:0]});
                chk("sb_mem_data", mem_data, e.data);
                chk("sb_reg_wen", {63'd0, o_reg_wen}, {63'd0, e.reg_wen});
                chk("sb_rd_addr", {59'd0, o_rd}, {59'd0, e.rd});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) step();
        smp();
        chk("rst_mwb_valid", {63'd0, mwb_valid}, 64'd0);
        chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_allowin", {63'd0, ex_allowin}, 64'd1);
        chk("rst_alu_out", {32'd0, alu_out}, 64'd0);
        chk("rst_mem_data", mem_data, 64'd0);
`ifdef YSYX_22040750_LSU_TIMEOUT_EN
        chk("rst_dmem_err", {63'd0, dmem_err}, 64'd0);
`endif
        step();
        rst = 1'b0;

        // Non-memory ops, back to back
        mwb_allowin = 1'b1;
        step(); issue(0, 0, 32'h0000_1234, '0, '0, 1, 5'd5); push(32'h0000_1234, 0, 1, 5'd5);
        smp();  chk("nm_allowin_idle", {63'd0, ex_allowin}, 64'd1);
        step(); issue(0, 0, 32'h2000_0008, '0, '0, 1, 5'd6); push(32'h2000_0008, 0, 1, 5'd6);
        smp();  chk("b2b_valid0", {63'd0, mwb_valid}, 64'd1);
        step(); issue(0, 0, 32'h0000_0033, '0, '0, 0, 5'd7); push(32'h0000_0033, 0, 0, 5'd7);
        smp();  chk("b2b_valid1", {63'd0, mwb_valid}, 64'd1);
        step(); issue(0, 0, 32'h0000_0044, '0, '0, 1, 5'd8); push(32'h0000_0044, 0, 1, 5'd8);
        smp();  chk("b2b_valid2", {63'd0, mwb_valid}, 64'd1);
        step(); idle_in();
        smp();  chk("b2b_valid3", {63'd0, mwb_valid}, 64'd1);
        step();
        smp();  chk("b2b_drain_idle", {63'd0, mwb_valid}, 64'd0);

        // Load: grant after 2 cycles, response 3 cycles after grant
        step(); issue(1, 0, 32'h8000_0013, '0, '0, 1, 5'd7);
        push(32'h8000_0013, 64'hDEAD_BEEF_CAFE_F00D, 1, 5'd7);
        smp();
        step(); idle_in();
        smp();  chk("ld_req", {63'd0, dmem_req}, 64'd1);
                chk("ld_addr_aligned", {32'd0, dmem_addr}, 64'h8000_0010);
                chk("ld_we", {63'd0, dmem_we}, 64'd0);
                chk("ld_allowin_req", {63'd0, ex_allowin}, 64'd0);
        step();
        smp();  chk("ld_req_wait", {63'd0, dmem_req}, 64'd1);
        step(); gnt = 1'b1;
        smp();  chk("ld_req_gnt", {63'd0, dmem_req}, 64'd1);
        step(); gnt = 1'b0;
        smp();  chk("ld_req_dropped", {63'd0, dmem_req}, 64'd0);
                chk("ld_allowin_resp", {63'd0, ex_allowin}, 64'd0);
        step();
        smp();  chk("ld_no_valid_resp", {63'd0, mwb_valid}, 64'd0);
        step(); rvalid = 1'b1; rdata = 64'hDEAD_BEEF_CAFE_F00D;
        smp();  chk("ld_allowin_rvalid", {63'd0, ex_allowin}, 64'd0);
        step(); rvalid = 1'b0; rdata = '0;
        smp();  chk("ld_valid_hold", {63'd0, mwb_valid}, 64'd1);
        step();

        // Store, with rvalid alongside the grant (must count as grant only)
        step(); issue(0, 1, 32'h0000_0100, 64'h0000_0000_1122_3344, 8'h0F, 0, 5'd0);
        push(32'h0000_0100, 0, 0, 5'd0);
        smp();
        step(); idle_in();
        smp();  chk("st_we", {63'd0, dmem_we}, 64'd1);
                chk("st_wstrb", {56'd0, dmem_wstrb}, 64'h0F);
                chk("st_wdata", dmem_wdata, 64'h1122_3344);
        step();
        smp();  chk("st_wstrb_stable", {56'd0, dmem_wstrb}, 64'h0F);
                chk("st_wdata_stable", dmem_wdata, 64'h1122_3344);
        step(); gnt = 1'b1; rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        smp();  chk("st_req_gnt", {63'd0, dmem_req}, 64'd1);
        step(); gnt = 1'b0; rvalid = 1'b0;
        smp();  chk("st_gnt_rvalid_is_grant_only", {63'd0, mwb_valid}, 64'd0);
        step(); rvalid = 1'b1;
        smp();
        step(); rvalid = 1'b0; rdata = '0;
        smp();  chk("st_valid_hold", {63'd0, mwb_valid}, 64'd1);
        step();
        smp();  chk("st_back_idle", {63'd0, mwb_valid}, 64'd0);

        // Backpressure for 5 cycles, then same-cycle accept
        step(); mwb_allowin = 1'b0; issue(0, 0, 32'h0000_00A0, '0, '0, 1, 5'd9);
        push(32'h0000_00A0, 0, 1, 5'd9);
        smp();
        step(); issue(0, 0, 32'h0000_00B8, '0, '0, 1, 5'd10);
        push(32'h0000_00B8, 0, 1, 5'd10);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            smp();
            chk("bp_valid", {63'd0, mwb_valid}, 64'd1);
            chk("bp_allowin", {63'd0, ex_allowin}, 64'd0);
            chk("bp_alu_stable", {32'd0, alu_out}, 64'h00A0);
        end
        step(); mwb_allowin = 1'b1;
        smp();  chk("bp_same_cycle_allowin", {63'd0, ex_allowin}, 64'd1);
        step(); idle_in();
        smp();  chk("bp_second_alu", {32'd0, alu_out}, 64'h00B8);
        step();

        // Reset while REQ: request drops without a clock edge
        step(); issue(1, 0, 32'h0000_0300, '0, '0, 1, 5'd2);
        smp();
        step(); idle_in();
        smp();  chk("rstreq_req_pre", {63'd0, dmem_req}, 64'd1);
        #2 rst = 1'b1;
        #1 chk("rstreq_async_drop", {63'd0, dmem_req}, 64'd0);
        step(); rst = 1'b0;
        smp();  chk("rstreq_valid", {63'd0, mwb_valid}, 64'd0);

        // Reset while RESP, then a stale response
        step(); issue(1, 0, 32'h0000_0200, '0, '0, 1, 5'd4);
        smp();
        step(); idle_in(); gnt = 1'b1;
        smp();
        step(); gnt = 1'b0;
        smp();  chk("rstresp_in_resp", {63'd0, ex_allowin}, 64'd0);
        #2 rst = 1'b1;
        #1 chk("rstresp_async_idle", {63'd0, ex_allowin}, 64'd1);
        step(); rst = 1'b0; rvalid = 1'b1; rdata = 64'h0123_4567_89AB_CDEF;
        smp();  chk("stale_rvalid_valid", {63'd0, mwb_valid}, 64'd0);
        step(); rvalid = 1'b0; rdata = '0;
        smp();  chk("stale_rvalid_valid2", {63'd0, mwb_valid}, 64'd0);
                chk("stale_rvalid_data", mem_data, 64'd0);
                chk("stale_rvalid_allowin", {63'd0, ex_allowin}, 64'd1);

`ifdef YSYX_22040750_LSU_TIMEOUT_EN
        // Response timeout after 4 RESP cycles
        begin
            int  n;
            bit  done;
            n    = 0;
            done = 1'b0;
            step(); issue(1, 0, 32'h0000_0040, '0, '0, 1, 5'd3);
            push(32'h0000_0040, 0, 1, 5'd3);
            smp();
            step(); idle_in(); gnt = 1'b1;
            smp();
            step(); gnt = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                smp();
                if (mwb_valid) done = 1'b1;
                else n++;
            end
            chk("to_reached_hold", {63'd0, done}, 64'd1);
            chk("to_resp_cycles", 64'(n), 64'd4);
            chk("to_dmem_err", {63'd0, dmem_err}, 64'd1);
            step();
            smp();  chk("to_err_sticky", {63'd0, dmem_err}, 64'd1);
        end
`endif

        repeat (2) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
